mem_access: RTL and testbench

Memory-access stage of the core pipeline, directly downstream of the ALU. It consumes the ALU result record and passes register-write results through unchanged. It runs loads and stores against the data memory over a req/ack handshake, with byte/half/word alignment, write strobes and load sign/zero extension. It stalls the upstream stage while a memory transaction is outstanding, and delivers a register-write record to write-back.

---
 rtl/corePckg.sv | 64 ++++++
 rtl/load_align.sv | 35 +++
 rtl/mem_access.sv | 164 ++++++++++++++++
 tb/tb_mem_access.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corePckg.sv
`default_nettype none
//==============================================================================
// Module      : corePckg
// Description : Shared core types: ALU/memory/register-write records, memory
//               funct3 encodings and memory-stage state encoding.
// Revision    : 1.0
//==============================================================================
package corePckg;

  localparam int cXLEN  = 32;
  localparam int cStrbW = cXLEN / 8;

  // Load/store funct3; stores reuse eLb/eLh/eLw as SB/SH/SW
  typedef enum logic [2:0] {
    eLb  = 3'b000,
    eLh  = 3'b001,
    eLw  = 3'b010,
    eLbu = 3'b100,
    eLhu = 3'b101
  } eMemOp;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tMemState;

  typedef struct packed {
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
    logic [4:0]       rdAddr;
    logic [2:0]       opType;
    logic             read;
    logic             write;
  } tMemOp;

  typedef struct packed {
    logic [4:0]       addr;
    logic [cXLEN-1:0] data;
    logic             dv;
  } tRegOp;

  typedef struct packed {
    tMemOp memOp;
    tRegOp regOp;
  } tAluOut;

  function automatic logic isIllegalMemOp(input tMemOp op);
    logic badLoad;
    logic badStore;
    badLoad  = op.read  & ((op.opType == 3'b011) | (op.opType == 3'b110) |
                           (op.opType == 3'b111));
    badStore = op.write & (op.opType >= 3'b011);
    return (op.read & op.write) | badLoad | badStore;
  endfunction

  // Low two funct3 bits give the access size for both loads and stores
  function automatic logic isMisaligned(input logic [2:0] opType,
                                        input logic [1:0] byteOff);
    return ((opType[1:0] == 2'b01) & byteOff[0]) |
           ((opType[1:0] == 2'b10) & (byteOff != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
//==============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half of a load word and sign- or
//               zero-extends it to cXLEN.
// Revision    : 1.0
//==============================================================================
module load_align
  import corePckg::*;
(
  input  logic [cXLEN-1:0] iRData,
  input  logic [1:0]       iByteOff,
  input  logic [2:0]       iOpType,
  output logic [cXLEN-1:0] oData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = iRData[{iByteOff, 3'b000} +: 8];
  assign w_half = iRData[{iByteOff[1], 4'b0000} +: 16];

  always_comb begin
    oData = iRData;
    case (iOpType)
      eLb:     oData = {{(cXLEN-8){w_byte[7]}}, w_byte};
      eLh:     oData = {{(cXLEN-16){w_half[15]}}, w_half};
      eLbu:    oData = {{(cXLEN-8){1'b0}}, w_byte};
      eLhu:    oData = {{(cXLEN-16){1'b0}}, w_half};
      default: oData = iRData;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
//==============================================================================
// Module      : mem_access
// Description : Memory-access pipeline stage: issues loads/stores over a
//               req/ack port, stalls upstream while outstanding, and forwards
//               register-write records to write-back.
// Revision    : 1.0
//==============================================================================
module mem_access
  import corePckg::*;
(
  input  logic              iClk,
  input  logic              iRst,
  input  tAluOut            iAluOut,
  output logic              oStall,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [cXLEN-1:0]  oMemAddr,
  output logic [cXLEN-1:0]  oMemWData,
  output logic [cStrbW-1:0] oMemWStrb,
  input  logic              iMemAck,
  input  logic [cXLEN-1:0]  iMemRData,
  output tRegOp             oRegOp,
  output logic              oExcept
);

  tMemState          r_state;
  tMemState          w_nextState;
  tMemOp             w_memOp;
  logic              w_memValid;
  logic              w_fault;
  logic              w_issue;
  logic [cStrbW-1:0] w_strb;
  logic [cXLEN-1:0]  w_wData;
  logic [cXLEN-1:0]  w_loadData;

  logic              r_memReq;
  logic              r_memWe;
  logic [cXLEN-1:0]  r_memAddr;
  logic [cXLEN-1:0]  r_memWData;
  logic [cStrbW-1:0] r_memWStrb;
  logic [4:0]        r_rdAddr;
  logic [2:0]        r_opType;
  logic [1:0]        r_byteOff;
  tRegOp             r_regOp;
  logic              r_except;

  assign w_memOp    = iAluOut.memOp;
  assign w_memValid = w_memOp.read | w_memOp.write;
  assign w_fault    = isIllegalMemOp(w_memOp) |
                      isMisaligned(w_memOp.opType, w_memOp.addr[1:0]);
  assign w_issue    = (r_state == IDLE) & w_memValid & ~w_fault;

  // The ack cycle drops the stall so upstream advances exactly once per op
  assign oStall = iRst & (w_issue | ((r_state == WAIT_ACK) & ~iMemAck));

  always_comb begin
    w_strb  = '0;
    w_wData = '0;
    if (w_memOp.write) begin
      case (w_memOp.opType[1:0])
        2'b00: begin
          w_strb  = cStrbW'(1) << w_memOp.addr[1:0];
          w_wData = {(cXLEN/8){w_memOp.data[7:0]}};
        end
        2'b01: begin
          w_strb  = w_memOp.addr[1] ? 4'b1100 : 4'b0011;
          w_wData = {(cXLEN/16){w_memOp.data[15:0]}};
        end
        default: begin
          w_strb  = '1;
          w_wData = w_memOp.data;
        end
      endcase
    end
  end

  load_align uLoadAlign (
    .iRData   (iMemRData),
    .iByteOff (r_byteOff),
    .iOpType  (r_opType),
    .oData    (w_loadData)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_issue) w_nextState = WAIT_ACK;
      WAIT_ACK: if (iMemAck) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWData <= '0;
      r_memWStrb <= '0;
      r_rdAddr   <= '0;
      r_opType   <= '0;
      r_byteOff  <= '0;
      r_regOp    <= '0;
      r_except   <= 1'b0;
    end else begin
      r_except <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_memReq   <= 1'b1;
            r_memWe    <= w_memOp.write;
            r_memAddr  <= {w_memOp.addr[cXLEN-1:2], 2'b00};
            r_memWData <= w_wData;
            r_memWStrb <= w_strb;
            r_rdAddr   <= w_memOp.rdAddr;
            r_opType   <= w_memOp.opType;
            r_byteOff  <= w_memOp.addr[1:0];
            r_regOp    <= '0;
          end else if (w_memValid) begin
            // A faulting memory op also swallows any accompanying regOp
            r_except <= 1'b1;
            r_regOp  <= '0;
          end else begin
            r_regOp.addr <= iAluOut.regOp.addr;
            r_regOp.data <= iAluOut.regOp.data;
            r_regOp.dv   <= iAluOut.regOp.dv & (iAluOut.regOp.addr != 5'd0);
          end
        end
        WAIT_ACK: begin
          if (iMemAck) begin
            r_memReq <= 1'b0;
            if (!r_memWe) begin
              r_regOp <= {r_rdAddr, w_loadData, (r_rdAddr != 5'd0)};
            end else begin
              r_regOp <= '0;
            end
          end else begin
            r_regOp <= '0;
          end
        end
        default: r_regOp <= '0;
      endcase
    end
  end

  assign oMemReq   = r_memReq;
  assign oMemWe    = r_memWe;
  assign oMemAddr  = r_memAddr;
  assign oMemWData = r_memWData;
  assign oMemWStrb = r_memWStrb;
  assign oRegOp    = r_regOp;
  assign oExcept   = r_except;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
//==============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access.
// Revision    : 1.0
//==============================================================================
module tb_mem_access;
  import corePckg::*;

  logic              iClk;
  logic              iRst;
  tAluOut            iAluOut;
  logic              oStall;
  logic              oMemReq;
  logic              oMemWe;
  logic [cXLEN-1:0]  oMemAddr;
  logic [cXLEN-1:0]  oMemWData;
  logic [cStrbW-1:0] oMemWStrb;
  logic              iMemAck;
  logic [cXLEN-1:0]  iMemRData;
  tRegOp             oRegOp;
  logic              oExcept;

  int checkCnt = 0;
  int errCnt   = 0;

  logic              capReq;
  logic              capWe;
  logic              capStall;
  logic [cXLEN-1:0]  capAddr;
  logic [cXLEN-1:0]  capWData;
  logic [cStrbW-1:0] capStrb;

  mem_access dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iAluOut   (iAluOut),
    .oStall    (oStall),
    .oMemReq   (oMemReq),
    .oMemWe    (oMemWe),
    .oMemAddr  (oMemAddr),
    .oMemWData (oMemWData),
    .oMemWStrb (oMemWStrb),
    .iMemAck   (iMemAck),
    .iMemRData (iMemRData),
    .oRegOp    (oRegOp),
    .oExcept   (oExcept)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic tAluOut mkOp(input logic rd, input logic wr, input logic [2:0] t,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [4:0] rdA);
    tAluOut x;
    x = '0;
    x.memOp.read   = rd;
    x.memOp.write  = wr;
    x.memOp.opType = t;
    x.memOp.addr   = a;
    x.memOp.data   = d;
    x.memOp.rdAddr = rdA;
    return x;
  endfunction

  // Presents op, acks in the first request cycle, ends mid-cycle after the ack edge
  task automatic doOp(input tAluOut op, input logic [31:0] rdata);
    @(posedge iClk); #1;
    iAluOut = op;
    @(posedge iClk); #1;
    iMemAck   = 1'b1;
    iMemRData = rdata;
    @(negedge iClk);
    capReq   = oMemReq;
    capWe    = oMemWe;
    capStall = oStall;
    capAddr  = oMemAddr;
    capWData = oMemWData;
    capStrb  = oMemWStrb;
    @(posedge iClk); #1;
    iMemAck = 1'b0;
    iAluOut = '0;
    @(negedge iClk);
  endtask

  task automatic faultOp(input string tag, input tAluOut op);
    @(posedge iClk); #1;
    iAluOut = op;
    @(negedge iClk);
    check({tag, "_stall"}, oStall, 0);
    @(posedge iClk); #1;
    iAluOut = '0;
    @(negedge iClk);
    check({tag, "_exc"}, oExcept, 1);
    check({tag, "_req"}, oMemReq, 0);
    check({tag, "_dv"}, oRegOp.dv, 0);
    @(posedge iClk); #1;
    @(negedge iClk);
    check({tag, "_excPulse"}, oExcept, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    iRst      = 1'b1;
    iAluOut   = '0;
    iMemAck   = 1'b0;
    iMemRData = '0;
    #1 iRst   = 1'b0;
    iAluOut   = mkOp(1, 0, eLw, 32'h100, 0, 5'd3);
    @(negedge iClk);
    check("rst_stall", oStall, 0);
    check("rst_req", oMemReq, 0);
    check("rst_regop", oRegOp, 0);
    check("rst_exc", oExcept, 0);
    check("rst_addr", oMemAddr, 0);
    iAluOut = '0;
    @(posedge iClk); #1;
    iRst = 1'b1;

    // LW 0x100 with ack in cycle 3
    @(posedge iClk); #1;
    iAluOut = mkOp(1, 0, eLw, 32'h100, 0, 5'd3);
    @(negedge iClk);
    check("lw_c0_stall", oStall, 1);
    check("lw_c0_req", oMemReq, 0);
    @(posedge iClk); #1;
    @(negedge iClk);
    check("lw_c1_req", oMemReq, 1);
    check("lw_c1_addr", oMemAddr, 32'h100);
    check("lw_c1_we", oMemWe, 0);
    check("lw_c1_strb", oMemWStrb, 0);
    check("lw_c1_stall", oStall, 1);
    @(posedge iClk); #1;
    @(negedge iClk);
    check("lw_c2_req", oMemReq, 1);
    check("lw_c2_stall", oStall, 1);
    @(posedge iClk); #1;
    iMemAck   = 1'b1;
    iMemRData = 32'hDEADBEEF;
    @(negedge iClk);
    check("lw_c3_req", oMemReq, 1);
    check("lw_c3_stall", oStall, 0);
    @(posedge iClk); #1;
    iMemAck = 1'b0;
    iAluOut = '0;
    @(negedge iClk);
    check("lw_c4_regop", oRegOp, {5'd3, 32'hDEADBEEF, 1'b1});
    check("lw_c4_req", oMemReq, 0);

    // Load extraction and extension
    doOp(mkOp(1, 0, eLb, 32'h103, 0, 5'd4), 32'h80FF_0000);
    check("lb_regop", oRegOp, {5'd4, 32'hFFFFFF80, 1'b1});
    check("lb_reqStall", capStall, 0);
    doOp(mkOp(1, 0, eLbu, 32'h103, 0, 5'd4), 32'h80FF_0000);
    check("lbu_regop", oRegOp, {5'd4, 32'h00000080, 1'b1});
    doOp(mkOp(1, 0, eLh, 32'h102, 0, 5'd4), 32'h80FF_0000);
    check("lh_regop", oRegOp, {5'd4, 32'hFFFF80FF, 1'b1});
    doOp(mkOp(1, 0, eLhu, 32'h100, 0, 5'd4), 32'h80FF_8001);
    check("lhu_regop", oRegOp, {5'd4, 32'h00008001, 1'b1});

    // Store lanes
    doOp(mkOp(0, 1, eLb, 32'h202, 32'h12, 5'd0), 0);
    check("sb_strb", capStrb, 4'b0100);
    check("sb_wdata", capWData, 32'h12121212);
    check("sb_addr", capAddr, 32'h200);
    check("sb_we", capWe, 1);
    check("sb_dv", oRegOp.dv, 0);
    doOp(mkOp(0, 1, eLh, 32'h202, 32'h0000ABCD, 5'd0), 0);
    check("sh_strb", capStrb, 4'b1100);
    check("sh_wdata", capWData, 32'hABCDABCD);
    doOp(mkOp(0, 1, eLw, 32'h204, 32'hCAFEF00D, 5'd0), 0);
    check("sw_strb", capStrb, 4'b1111);
    check("sw_addr", capAddr, 32'h204);
    check("sw_wdata", capWData, 32'hCAFEF00D);

    // Faults
    faultOp("lh_mis", mkOp(1, 0, eLh, 32'h101, 0, 5'd2));
    faultOp("rw_both", mkOp(1, 1, eLw, 32'h100, 0, 5'd2));
    faultOp("st_bad", mkOp(0, 1, 3'b011, 32'h100, 0, 5'd0));
    faultOp("lw_mis", mkOp(1, 0, eLw, 32'h102, 0, 5'd2));
    faultOp("ld_bad", mkOp(1, 0, 3'b110, 32'h100, 0, 5'd2));

    // Register passthrough
    @(posedge iClk); #1;
    iAluOut = '0;
    iAluOut.regOp.addr = 5'd5;
    iAluOut.regOp.data = 32'h55;
    iAluOut.regOp.dv   = 1'b1;
    @(negedge iClk);
    check("pt_before", oRegOp.dv, 0);
    @(posedge iClk); #1;
    iAluOut = '0;
    @(negedge iClk);
    check("pt_regop", oRegOp, {5'd5, 32'h55, 1'b1});
    @(posedge iClk); #1;
    iAluOut.regOp.addr = 5'd0;
    iAluOut.regOp.data = 32'h66;
    iAluOut.regOp.dv   = 1'b1;
    @(posedge iClk); #1;
    iAluOut = '0;
    @(negedge iClk);
    check("pt_x0_dv", oRegOp.dv, 0);

    // Load to x0
    doOp(mkOp(1, 0, eLw, 32'h300, 0, 5'd0), 32'h11112222);
    check("lw_x0_req", capReq, 1);
    check("lw_x0_dv", oRegOp.dv, 0);

    // Memory op and regOp together: regOp is dropped
    @(posedge iClk); #1;
    iAluOut = mkOp(1, 0, eLw, 32'h100, 0, 5'd6);
    iAluOut.regOp.addr = 5'd7;
    iAluOut.regOp.data = 32'h77;
    iAluOut.regOp.dv   = 1'b1;
    @(posedge iClk); #1;
    @(negedge iClk);
    check("both_dv", oRegOp.dv, 0);
    check("both_req", oMemReq, 1);
    iMemAck   = 1'b1;
    iMemRData = 32'h11;
    @(posedge iClk); #1;
    iMemAck = 1'b0;
    iAluOut = '0;
    @(negedge iClk);
    check("both_regop", oRegOp, {5'd6, 32'h11, 1'b1});

    // Reset while waiting for ack
    @(posedge iClk); #1;
    iAluOut = mkOp(1, 0, eLw, 32'h400, 0, 5'd9);
    @(posedge iClk); #1;
    @(negedge iClk);
    check("mrst_reqBefore", oMemReq, 1);
    #1;
    iRst    = 1'b0;
    iAluOut = '0;
    #1;
    check("mrst_req", oMemReq, 0);
    check("mrst_addr", oMemAddr, 0);
    check("mrst_stall", oStall, 0);
    check("mrst_regop", oRegOp, 0);
    @(posedge iClk); #1;
    iRst      = 1'b1;
    iMemAck   = 1'b1;
    iMemRData = 32'hFFFFFFFF;
    @(negedge iClk);
    check("late_stall", oStall, 0);
    @(posedge iClk); #1;
    iMemAck = 1'b0;
    @(negedge iClk);
    check("late_dv", oRegOp.dv, 0);
    check("late_req", oMemReq, 0);
    doOp(mkOp(1, 0, eLw, 32'h500, 0, 5'd10), 32'h1234);
    check("post_req", capReq, 1);
    check("post_regop", oRegOp, {5'd10, 32'h1234, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
`default_nettype wire
